vga_console_writer: RTL and testbench

- Sequential writer into the dual-port character/colour RAM that the 800×600 text-mode VGA scanner reads on its other port.
- Accepts a stream of put-char, newline, backspace and clear commands from the CPU MMIO side.
- Tracks a cursor over the 96×32 cell grid and produces one RAM write per cycle.
- Fills rows or the whole screen with blanks when a line advance or a clear requires it.

---
 rtl/vga_console_writer.sv | 154 +++++++++++++++
 tb/tb_vga_console_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_writer.sv
// Cursor-tracking writer into the text-mode VGA character/colour RAM: one RAM write per cycle.
// Define VGA_CONSOLE_AUTOWRAP_EN so that a put char at the last column advances to a new, blanked line.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | accepting commands; single-write commands stay here
// S_CLR_ROW | blanking the 96 cells of row cursor_y, column 0 upward
// S_CLR_ALL | blanking all 3072 cells, address 0 upward (also after reset)
module vga_console_writer #(
    parameter int COLS     = 96,
    parameter int ROWS     = 32,
    parameter int BLANK_CH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_cmd,
    input  logic [7:0]  in_char,
    input  logic [7:0]  in_color,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_ch,
    output logic [7:0]  wr_color,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLR_ROW = 2'd1;
    localparam logic [1:0] S_CLR_ALL = 2'd2;

    localparam logic [1:0] CMD_PUT = 2'd0;
    localparam logic [1:0] CMD_NL  = 2'd1;
    localparam logic [1:0] CMD_BS  = 2'd2;
    localparam logic [1:0] CMD_CLR = 2'd3;

    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [11:0] ROW_CELLS = 12'(COLS);
    localparam logic [11:0] ALL_CELLS = 12'(COLS * ROWS);
    localparam logic [7:0]  BLANK     = 8'(BLANK_CH);

    logic [1:0]  state;
    logic [11:0] fill_addr;
    logic [11:0] fill_cnt;
    logic [4:0]  next_y;
    logic [11:0] cur_addr;
    logic [11:0] next_base;

    // y*96 as y*64 + y*32, no multiplier
    function automatic logic [11:0] row_base(input logic [4:0] y);
        row_base = ({7'd0, y} << 6) + ({7'd0, y} << 5);
    endfunction

    assign next_y    = cursor_y + 5'd1;
    assign cur_addr  = row_base(cursor_y) + {5'd0, cursor_x};
    assign next_base = row_base(next_y);
    assign in_ready  = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLR_ALL;
            fill_addr <= 12'd0;
            fill_cnt  <= ALL_CELLS;
            cursor_x  <= 7'd0;
            cursor_y  <= 5'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 12'd0;
            wr_ch     <= 8'd0;
            wr_color  <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (in_cmd)
                            CMD_PUT: begin
                                wr_en    <= 1'b1;
                                wr_addr  <= cur_addr;
                                wr_ch    <= in_char;
                                wr_color <= in_color;
                                if (cursor_x != LAST_COL)
                                    cursor_x <= cursor_x + 7'd1;
`ifdef VGA_CONSOLE_AUTOWRAP_EN
                                else begin
                                    // fill starts the cycle after the character write
                                    cursor_x  <= 7'd0;
                                    cursor_y  <= next_y;
                                    fill_addr <= next_base;
                                    fill_cnt  <= ROW_CELLS;
                                    state     <= S_CLR_ROW;
                                end
`endif
                            end
                            CMD_NL: begin
                                // first blank goes out with the command; the fill covers the rest
                                cursor_x  <= 7'd0;
                                cursor_y  <= next_y;
                                wr_en     <= 1'b1;
                                wr_addr   <= next_base;
                                wr_ch     <= BLANK;
                                wr_color  <= 8'd0;
                                fill_addr <= next_base + 12'd1;
                                fill_cnt  <= ROW_CELLS - 12'd1;
                                state     <= S_CLR_ROW;
                            end
                            CMD_BS: begin
                                if (cursor_x != 7'd0 || cursor_y != 5'd0) begin
                                    wr_en    <= 1'b1;
                                    wr_addr  <= cur_addr - 12'd1;
                                    wr_ch    <= BLANK;
                                    wr_color <= 8'd0;
                                    if (cursor_x != 7'd0) begin
                                        cursor_x <= cursor_x - 7'd1;
                                    end else begin
                                        cursor_x <= LAST_COL;
                                        cursor_y <= cursor_y - 5'd1;
                                    end
                                end
                            end
                            CMD_CLR: begin
                                cursor_x  <= 7'd0;
                                cursor_y  <= 5'd0;
                                wr_en     <= 1'b1;
                                wr_addr   <= 12'd0;
                                wr_ch     <= BLANK;
                                wr_color  <= 8'd0;
                                fill_addr <= 12'd1;
                                fill_cnt  <= ALL_CELLS - 12'd1;
                                state     <= S_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLR_ROW, S_CLR_ALL: begin
                    // down-counter of remaining writes; zero means the last one is on the bus
                    if (fill_cnt == 12'd0) begin
                        state <= S_IDLE;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_addr   <= fill_addr;
                        wr_ch     <= BLANK;
                        wr_color  <= 8'd0;
                        fill_addr <= fill_addr + 12'd1;
                        fill_cnt  <= fill_cnt - 12'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console_writer.sv
// Scoreboard bench for vga_console_writer: stimulus pushes expected RAM writes, a negedge monitor pops and compares.
module tb_vga_console_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_cmd = 2'd0;
    logic [7:0]  in_char = 8'd0;
    logic [7:0]  in_color = 8'd0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_ch;
    logic [7:0]  wr_color;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  ch;
        logic [7:0]  color;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  mx = 0;
    int  my = 0;

    vga_console_writer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cmd   (in_cmd),
        .in_char  (in_char),
        .in_color (in_color),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_ch    (wr_ch),
        .wr_color (wr_color),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    always #5 clk = ~clk;

    // monitor: every presented write must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d ch=%0d color=%0d, required no write",
                         wr_addr, wr_ch, wr_color);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_ch, wr_color} !== e) begin
                    failures++;
                    $display("FAIL write: got addr=%0d ch=%0d color=%0d, required addr=%0d ch=%0d color=%0d",
                             wr_addr, wr_ch, wr_color, e.addr, e.ch, e.color);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        check({name, "_x"}, 32'(cursor_x), x);
        check({name, "_y"}, 32'(cursor_y), y);
    endtask

    task automatic push_fill(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({12'(base + i), 8'd32, 8'd0});
    endtask

    // counts negedges with in_ready low, starting at the next negedge
    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got in_ready=%0d after %0d cycles, required 1", in_ready, n);
        end
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] ch, input logic [7:0] col);
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_ready: got in_ready=%0d, required 1", in_ready);
        end
        in_cmd   = cmd;
        in_char  = ch;
        in_color = col;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_char  = 8'hxx;
    endtask

    task automatic do_put(input int ch, input int col);
        exp_q.push_back({12'(my * 96 + mx), 8'(ch), 8'(col)});
        if (mx < 95) begin
            mx++;
        end else begin
`ifdef VGA_CONSOLE_AUTOWRAP_EN
            mx = 0;
            my = (my + 1) % 32;
            push_fill(my * 96, 96);
`endif
        end
        send(2'd0, 8'(ch), 8'(col));
    endtask

    task automatic do_nl();
        mx = 0;
        my = (my + 1) % 32;
        push_fill(my * 96, 96);
        send(2'd1, 8'd0, 8'd0);
    endtask

    task automatic do_bs();
        if (mx > 0) begin
            mx--;
            push_fill(my * 96 + mx, 1);
        end else if (my > 0) begin
            mx = 95;
            my--;
            push_fill(my * 96 + mx, 1);
        end
        send(2'd2, 8'd0, 8'd0);
    endtask

    task automatic do_clr();
        mx = 0;
        my = 0;
        push_fill(0, 3072);
        send(2'd3, 8'd0, 8'd0);
    endtask

    initial begin
        int n;

        // reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check_cursor("rst_cursor", 0, 0);
        push_fill(0, 3072);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wait_ready(n);
        check("reset_fill_cycles", n, 3072);
        check("reset_fill_drained", exp_q.size(), 0);
        check_cursor("after_reset", 0, 0);

        // back-to-back put chars
        do_put(72, 2);
        do_put(105, 5);
        @(negedge clk);
        check("put_in_ready", 32'(in_ready), 1);
        check_cursor("put_cursor", 2, 0);
        @(negedge clk);
        check("put_drained", exp_q.size(), 0);

        // walk down to row 31, column 10, then newline wraps to row 0
        for (int i = 0; i < 31; i++) begin
            do_nl();
            wait_ready(n);
        end
        for (int i = 0; i < 10; i++) do_put(97 + i, i % 7);
        @(negedge clk);
        check_cursor("pre_wrap", 10, 31);
        do_nl();
        wait_ready(n);
        check("nl_busy_cycles", n, 96);
        check_cursor("nl_wrap", 0, 0);
        check("nl_drained", exp_q.size(), 0);

        // backspace from the start of row 5
        for (int i = 0; i < 5; i++) begin
            do_nl();
            wait_ready(n);
        end
        check_cursor("pre_bs", 0, 5);
        do_bs();
        @(negedge clk);
        check("bs_wr_en", 32'(wr_en), 1);
        check("bs_addr", 32'(wr_addr), 479);
        check_cursor("bs_cursor", 95, 4);

        // clear screen, then backspace at origin does nothing
        @(negedge clk);
        do_clr();
        wait_ready(n);
        check("clr_busy_cycles", n, 3072);
        check_cursor("clr_cursor", 0, 0);
        do_bs();
        @(negedge clk);
        check("bs_origin_wr_en", 32'(wr_en), 0);
        check_cursor("bs_origin_cursor", 0, 0);
        @(negedge clk);
        check("bs_origin_ready", 32'(in_ready), 1);

        // put char at column 95 of row 3
        for (int i = 0; i < 3; i++) begin
            do_nl();
            wait_ready(n);
        end
        for (int i = 0; i < 95; i++) do_put(48 + (i % 10), i % 7);
        @(negedge clk);
        check_cursor("pre_col95", 95, 3);
        do_put(65, 1);
        @(negedge clk);
        check("col95_addr", 32'(wr_addr), 383);
        check("col95_ch", 32'(wr_ch), 65);
        wait_ready(n);
`ifdef VGA_CONSOLE_AUTOWRAP_EN
        check("col95_busy_cycles", n, 96);
        check_cursor("col95_cursor", 0, 4);
        check("col95_drained", exp_q.size(), 0);
`else
        check("col95_busy_cycles", n, 0);
        check_cursor("col95_cursor", 95, 3);
        do_put(66, 3);
        @(negedge clk);
        check("col95_overwrite_addr", 32'(wr_addr), 383);
        check_cursor("col95_overwrite_cursor", 95, 3);
`endif

        // reset during the 1000th write of a clear
        @(negedge clk);
        do_put(88, 4);
        @(negedge clk);
        do_clr();
        repeat (999) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_remaining", exp_q.size(), 2072);
        exp_q.delete();
        @(negedge clk);
        check("abort_wr_en", 32'(wr_en), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        push_fill(0, 3072);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wait_ready(n);
        check("restart_fill_cycles", n, 3072);
        check("restart_drained", exp_q.size(), 0);
        check_cursor("restart_cursor", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
